// File: rtl/uart_key_pkg.sv
// uart_key_pkg: shared constants, state types and key-character decode for uart_key_rx
package uart_key_pkg;
    localparam int DEF_CLKS_PER_BIT = 2812;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_2    = 8'h32;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} bit_state_t;
    typedef enum logic {EXPECT_PREFIX, EXPECT_KEY} parse_state_t;

    // Returns {valid, code}; "A".."D" low nibble is 1..4, hence the +9
    function automatic logic [4:0] ascii_to_key(input logic [7:0] b);
        if (b >= ASCII_0 && b <= ASCII_9) return {1'b1, b[3:0]};
        if (b >= ASCII_A && b <= ASCII_D) return {1'b1, b[3:0] + 4'd9};
        if (b == ASCII_HASH) return 5'h1E;
        if (b == ASCII_STAR) return 5'h1F;
        return 5'h00;
    endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchroniser and 8N1 bit-level receiver
module uart_rx_core import uart_key_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    logic sync1, line, line_q, ferr_nx;
    bit_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] shift, shift_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_q    <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= uart_rx;
            line      <= sync1;
            line_q    <= line;
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            shift     <= shift_nx;
            frame_err <= ferr_nx;
        end
    end

    // Counter is loaded with 1 so that a compare against N fires N cycles after the load
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CW'(1);
        idx_nx    = idx;
        shift_nx  = shift;
        ferr_nx   = 1'b0;
        byte_done = 1'b0;
        case (state)
            IDLE: if (line_q && !line) begin
                state_nx = START;
                cnt_nx   = CW'(1);
            end
            START: if (cnt == HALF) begin
                state_nx = line ? IDLE : DATA;
                cnt_nx   = CW'(1);
                idx_nx   = '0;
            end
            DATA: if (cnt == FULL) begin
                shift_nx = {line, shift[7:1]};
                idx_nx   = idx + 3'd1;
                cnt_nx   = CW'(1);
                state_nx = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == FULL) begin
                byte_done = line;
                ferr_nx   = !line;
                state_nx  = line ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: state_nx = line ? IDLE : WAIT_IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign byte_data = shift;
    assign rx_busy   = (state == DATA) || (state == STOP);
endmodule

// File: rtl/uart_key_rx.sv
// uart_key_rx: keypad serial link receiver; parses "2"+key messages into a key-code FIFO
module uart_key_rx import uart_key_pkg::*; #(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0] PREFIX       = ASCII_2,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       seq_err,
    output logic       overflow,
    output logic       rx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic       byte_done, push_q, push_nx, seq_nx, full, pop, wr_en;
    logic [7:0] byte_data;
    logic [4:0] key;
    logic [3:0] push_code;
    logic [3:0] mem [FIFO_DEPTH];
    logic [AW:0] wr, rd;
    parse_state_t ps, ps_nx;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .byte_done (byte_done),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    assign key = ascii_to_key(byte_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps        <= EXPECT_PREFIX;
            push_q    <= 1'b0;
            push_code <= 4'h0;
            seq_err   <= 1'b0;
        end else begin
            ps        <= ps_nx;
            push_q    <= push_nx;
            push_code <= key[3:0];
            seq_err   <= seq_nx;
        end
    end

    always_comb begin
        ps_nx   = ps;
        push_nx = 1'b0;
        seq_nx  = 1'b0;
        if (frame_err) ps_nx = EXPECT_PREFIX;
        else if (byte_done && ps == EXPECT_PREFIX) begin
            ps_nx  = (byte_data == PREFIX) ? EXPECT_KEY : EXPECT_PREFIX;
            seq_nx = byte_data != PREFIX;
        end else if (byte_done) begin
            ps_nx   = EXPECT_PREFIX;
            push_nx = key[4];
            seq_nx  = !key[4];
        end
    end

    // Wrap bit of the pointers separates full from empty
    assign key_valid = wr != rd;
    assign full      = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign pop       = key_valid && key_ready;
    assign wr_en     = push_q && (!full || pop);
    assign key_code  = key_valid ? mem[rd[AW-1:0]] : 4'h0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr[AW-1:0]] <= push_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr       <= '0;
            rd       <= '0;
            overflow <= 1'b0;
        end else begin
            wr       <= wr + (AW+1)'(wr_en);
            rd       <= rd + (AW+1)'(pop);
            overflow <= overflow || (push_q && full && !pop);
        end
    end
endmodule

// File: tb/tb_uart_key_rx.sv
// tb_uart_key_rx: directed bench for uart_key_rx with a shortened bit period
module tb_uart_key_rx;
    localparam int CPB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic       key_ready = 1'b0;
    logic [3:0] key_code;
    logic       key_valid, frame_err, seq_err, overflow, rx_busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, seq_cnt = 0, busy_cnt = 0, pop_cnt = 0;
    logic [3:0] last_code = 4'h0;
    int fe0, seq0, busy0, pop0;

    uart_key_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .overflow  (overflow),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (seq_err) seq_cnt++;
        if (rx_busy) busy_cnt++;
        if (key_valid && key_ready) begin
            pop_cnt++;
            last_code = key_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_msg(input logic [7:0] k);
        send_byte(8'h32, 1'b1);
        send_byte(k, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic snap();
        fe0 = fe_cnt; seq0 = seq_cnt; busy0 = busy_cnt; pop0 = pop_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {rx_busy, key_valid, key_code, overflow, frame_err, seq_err}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        key_ready = 1'b1;
        snap();
        send_msg(8'h35);
        check("t1_pops", pop_cnt - pop0, 1);
        check("t1_code", last_code, 4'h5);
        check("t1_frame_err", fe_cnt - fe0, 0);
        check("t1_seq_err", seq_cnt - seq0, 0);
        check("t1_busy_cycles", busy_cnt - busy0, 576);

        key_ready = 1'b0;
        send_msg(8'h2A);
        send_msg(8'h23);
        send_msg(8'h32);
        check("t2_head_star", {key_valid, key_code}, 5'h1F);
        pop_one();
        check("t2_head_hash", {key_valid, key_code}, 5'h1E);
        pop_one();
        check("t2_head_two", {key_valid, key_code}, 5'h12);
        pop_one();
        check("t2_empty", key_valid, 1'b0);

        snap();
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy", busy_cnt - busy0, 0);
        check("glitch_errs", (fe_cnt - fe0) + (seq_cnt - seq0), 0);
        check("glitch_valid", key_valid, 1'b0);

        key_ready = 1'b1;
        snap();
        send_byte(8'h32, 1'b1);
        send_byte(8'h32, 1'b0);
        repeat (8) @(negedge clk);
        send_byte(8'h35, 1'b1);
        repeat (10) @(negedge clk);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_seq_err", seq_cnt - seq0, 1);
        check("ferr_no_push", pop_cnt - pop0, 0);

        key_ready = 1'b0;
        send_msg(8'h31);
        send_msg(8'h33);
        send_msg(8'h37);
        send_msg(8'h41);
        send_msg(8'h42);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_head1", {key_valid, key_code}, 5'h11);
        pop_one();
        check("ovf_head3", {key_valid, key_code}, 5'h13);
        pop_one();
        check("ovf_head7", {key_valid, key_code}, 5'h17);
        repeat (20) @(negedge clk);
        check("ovf_sticky", overflow, 1'b1);

        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i == 1);
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("pre_reset_busy", rx_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("in_reset_outputs", {rx_busy, key_valid, key_code, overflow, frame_err, seq_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        key_ready = 1'b1;
        snap();
        send_msg(8'h39);
        check("post_reset_pops", pop_cnt - pop0, 1);
        check("post_reset_code", last_code, 4'h9);
        check("post_reset_seq_err", seq_cnt - seq0, 0);
        check("post_reset_ovf", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
